// File: rtl/adc_seq.sv
// adc_seq: init/type/conf handshake then periodic conversions for the adc block.
// Define ADC_SEQ_TIMEOUT_EN to add the fd_* wait watchdog and ERR entry.
`timescale 1ns/1ps
module adc_seq #(
  parameter int unsigned CONV_BASE = 20000,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [2:0]  freq,
  input  logic [7:0]  type_in,
  input  logic        fd_init,
  input  logic        fd_type,
  input  logic        fd_conf,
  input  logic        fd_conv,
  output logic        fs_init,
  output logic        fs_type,
  output logic        fs_conf,
  output logic        fs_conv,
  output logic [7:0]  type_lat,
  output logic        busy,
  output logic        ready,
  output logic        conv_done,
  output logic [15:0] frame_cnt,
  output logic [7:0]  overrun_cnt,
  output logic        err
);

  localparam int PW = $clog2(CONV_BASE + 1);

  typedef enum logic [2:0] {
    IDLE, INIT, TYPE, CONF,
    READY, CONV, DONE, ERR
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [2:0]    f_lat;
  logic [PW-1:0] tcnt;
  logic [PW-1:0] per_m1;
  logic          run;
  logic          tick;
  logic          stop_pend;
  logic          tmo;

  assign per_m1 = PW'((CONV_BASE >> f_lat) - 1);
  assign run    = state inside {READY, CONV, DONE};
  assign tick   = run && (tcnt == per_m1);

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wcnt;

  assign tmo = (wcnt == WW'(TIMEOUT - 1));

  // Restarts on every state change, so each wait state gets a full budget
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
    end else if (nxt != state) begin
      wcnt <= '0;
    end else if (!tmo) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign tmo            = 1'b0;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = INIT;
      INIT: begin
        if (fd_init)  nxt = TYPE;
        else if (tmo) nxt = ERR;
      end
      TYPE: begin
        if (fd_type)  nxt = CONF;
        else if (tmo) nxt = ERR;
      end
      CONF: begin
        if (fd_conf)  nxt = READY;
        else if (tmo) nxt = ERR;
      end
      READY: begin
        if (stop)      nxt = IDLE;
        else if (tick) nxt = CONV;
      end
      CONV: begin
        if (fd_conv)  nxt = DONE;
        else if (tmo) nxt = ERR;
      end
      DONE:  nxt = (stop_pend || stop) ? IDLE : READY;
      ERR:   if (start) nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fs_init     <= 1'b0;
      fs_type     <= 1'b0;
      fs_conf     <= 1'b0;
      fs_conv     <= 1'b0;
      type_lat    <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      conv_done   <= 1'b0;
      frame_cnt   <= '0;
      overrun_cnt <= '0;
      err         <= 1'b0;
      f_lat       <= '0;
      tcnt        <= '0;
      stop_pend   <= 1'b0;
    end else begin
      state     <= nxt;
      fs_init   <= (nxt == INIT);
      fs_type   <= (nxt == TYPE);
      fs_conf   <= (nxt == CONF);
      fs_conv   <= (nxt == CONV);
      busy      <= !(nxt inside {IDLE, ERR});
      ready     <= (nxt == READY);
      conv_done <= (nxt == DONE);
      err       <= (nxt == ERR);
      // A stop seen mid-conversion is honoured only after DONE
      stop_pend <= (state == CONV) && (stop_pend || stop);
      if (state == TYPE && fd_type) begin
        type_lat <= type_in;
      end
      if (state == CONF && fd_conf) begin
        f_lat       <= (freq > 3'd5) ? 3'd5 : freq;
        tcnt        <= '0;
        frame_cnt   <= '0;
        overrun_cnt <= '0;
      end else begin
        if (run) begin
          tcnt <= tick ? '0 : tcnt + 1'b1;
        end
        if (nxt == DONE) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
        if (state == CONV && tick && overrun_cnt != 8'hFF) begin
          overrun_cnt <= overrun_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/adc_seq.md
# adc_seq

Control sequencer directly upstream of the four-chip `adc` block. It drives the `fs_init`/`fs_type`/`fs_conf`/`fs_conv` start strobes, waits for the matching `fd_*` completions, and latches the chip type word. It then issues periodic conversions at a rate set by `freq`, and reports each completed frame to the downstream packer with a one-cycle `conv_done` pulse and a frame counter.

## Interface
- `CONV_BASE`, default 20000: conversion period in `clk` cycles at `freq`=0.
- `TIMEOUT`, default 1000000: maximum wait in `clk` cycles for any `fd_*` (used only with `ADC_SEQ_TIMEOUT_EN`).
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle request to run init/type/conf, then begin sampling.
- `stop`, input, 1: one-cycle request to halt sampling.
- `freq`, input, 3: sample-rate code, latched on entry to READY.
- `type_in`, input, 8: chip type word from `adc`.
- `fd_init`, `fd_type`, `fd_conf`, `fd_conv`, input, 1 each: completion levels from `adc`.
- `fs_init`, `fs_type`, `fs_conf`, `fs_conv`, output, 1 each: start levels to `adc`.
- `type_lat`, output, 8: type word captured at `fd_type`.
- `busy`, output, 1: high in every state except IDLE and ERR.
- `ready`, output, 1: high in READY.
- `conv_done`, output, 1: one-cycle pulse per completed conversion.
- `frame_cnt`, output, 16: completed conversions since the last init; wraps from 0xFFFF to 0.
- `overrun_cnt`, output, 8: ticks lost while a conversion was still pending; saturates at 255.
- `err`, output, 1: sticky timeout flag.

## Operation
- States are IDLE, INIT, TYPE, CONF, READY, CONV, DONE and ERR. All outputs are registered.
- While `rst` is low, every output is 0 and the state is IDLE.
- IDLE: `start` moves to INIT. `stop` is ignored.
- INIT, TYPE and CONF each hold their `fs_*` high until the matching `fd_*` is sampled high.
  - INIT then moves to TYPE.
  - TYPE moves to CONF and loads `type_lat` from `type_in` in the same cycle.
  - CONF moves to READY. On this transition the sequencer latches `freq`, clears the tick counter, clears `frame_cnt` and clears `overrun_cnt`.
- Period P = `CONV_BASE` >> f, where f = latched `freq` clamped to a maximum of 5.
- Tick counter: runs from 0 to P−1 in READY, CONV and DONE, then wraps. A tick occurs on the cycle the counter equals P−1.
- READY:
  - A tick moves to CONV.
  - `stop` moves to IDLE.
  - If `stop` and a tick arrive in the same cycle, `stop` wins.
- CONV: `fs_conv` is high until `fd_conv` is sampled high, then the state moves to DONE. A tick arriving during CONV increments `overrun_cnt` (saturating) and is dropped.
- DONE lasts one cycle: `conv_done` is 1 and `frame_cnt` increments. It then moves to READY, or to IDLE if a `stop` was recorded during CONV or DONE.
- A `stop` during CONV/DONE is held in a pending flag until DONE completes; a conversion is never aborted.
- `start` is ignored outside IDLE and ERR.
- ERR: all `fs_*` are 0 and `err` is 1. `start` clears `err` and moves to INIT.
- An `fd_*` that stays high across states is harmless: each state checks only its own `fd_*`.

## Timing
- `start` sampled in cycle N gives `fs_init`=1 in cycle N+1.
- `fd_X` sampled high in cycle M gives `fs_X`=0 in cycle M+1, and the next strobe high in M+1.
- `fd_conf` high in cycle M gives `ready`=1 in cycle M+1.
- Tick in cycle T gives `fs_conv`=1 in cycle T+1.
- `fd_conv` high in cycle C gives `conv_done`=1 in cycle C+1 and `ready`=1 in cycle C+2.
- The conversion period is exact, P cycles tick-to-tick, and is independent of conversion latency.

## Configuration
- `ADC_SEQ_TIMEOUT_EN` defined:
  - A wait counter clears on each entry to INIT, TYPE, CONF or CONV.
  - Reaching `TIMEOUT` cycles without the matching `fd_*` moves to ERR and sets `err`=1 on the next cycle.
- Not defined: no wait counter; states wait indefinitely and `err` is tied to 0.

## Test plan
- Reset then handshake: release `rst`, pulse `start`, respond to each `fs_*` with `fd_*` after 3 cycles.
  - Expect `fs_init`, `fs_type`, `fs_conf` in sequence, each dropping the cycle after its `fd_*`.
  - With `type_in`=0xA5, expect `type_lat`=0xA5 and `ready`=1 one cycle after `fd_conf`.
- Rate: `CONV_BASE`=64, `freq`=2, `fd_conv` after 4 cycles.
  - Expect `fs_conv` rising edges exactly 16 cycles apart and `frame_cnt` 0→1→2→3.
  - Expect `conv_done` to be exactly one cycle wide.
- Overrun: P=16 with `fd_conv` delayed 40 cycles. Expect `overrun_cnt`=2 and `frame_cnt`=1 after the first conversion.
- Stop handling:
  - `stop` mid-CONV: expect the conversion to complete, `conv_done` to pulse once, then IDLE with `busy`=0.
  - `stop` coincident with a tick in READY: expect no `fs_conv`.
- Timeout (with macro, `TIMEOUT`=100): never assert `fd_type`. Expect `err`=1 and `fs_type`=0 after 100 cycles in TYPE; a following `start` re-enters INIT with `err`=0.
- Async reset mid-CONV: drive `rst` low between clock edges. Expect all outputs 0 immediately, without waiting for a clock edge.
